// File: rtl/controller.sv
// controller: arbitrates NUM_CONSUMERS read/write requesters onto NUM_CHANNELS memory channels.
// Define CONTROLLER_ASSERT_EN to enable simulation-only protocol checks.
module controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] consumer_write_address,
  input  logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [DATA_BITS*NUM_CHANNELS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_write_address,
  output logic [DATA_BITS*NUM_CHANNELS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  state_t                   state_q [NUM_CHANNELS];
  state_t                   state_d [NUM_CHANNELS];
  logic [CW-1:0]            owner_q [NUM_CHANNELS];
  logic [CW-1:0]            owner_d [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] serving_q, serving_d, claimed;
  logic                     found;
  int                       own;

  logic [NUM_CONSUMERS-1:0]           crr_d, cwr_d;
  logic [DATA_BITS*NUM_CONSUMERS-1:0] crd_d;
  logic [NUM_CHANNELS-1:0]            mrv_d, mwv_d;
  logic [ADDR_BITS*NUM_CHANNELS-1:0]  mra_d, mwa_d;
  logic [DATA_BITS*NUM_CHANNELS-1:0]  mwd_d;

  // Channels are visited in index order so a lower channel claims first; 'claimed'
  // starts from the registered serving set, so a consumer released on this edge
  // can only be claimed again on the following edge.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    serving_d = serving_q;
    claimed   = serving_q;
    found     = 1'b0;
    own       = 0;
    crr_d     = consumer_read_ready;
    cwr_d     = consumer_write_ready;
    crd_d     = consumer_read_data;
    mrv_d     = mem_read_valid;
    mra_d     = mem_read_address;
    mwv_d     = mem_write_valid;
    mwa_d     = mem_write_address;
    mwd_d     = mem_write_data;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      own = int'(owner_q[ch]);
      case (state_q[ch])
        IDLE: begin
          found = 1'b0;
          for (int c = 0; c < NUM_CONSUMERS; c++) begin
            if (!found && !claimed[c] &&
                (consumer_read_valid[c] || (WRITE_ENABLE != 0 && consumer_write_valid[c]))) begin
              found        = 1'b1;
              claimed[c]   = 1'b1;
              serving_d[c] = 1'b1;
              owner_d[ch]  = CW'(c);
              if (consumer_read_valid[c]) begin
                mrv_d[ch]                          = 1'b1;
                mra_d[ch*ADDR_BITS +: ADDR_BITS]   = consumer_read_address[c*ADDR_BITS +: ADDR_BITS];
                state_d[ch]                        = READ_WAITING;
              end else begin
                mwv_d[ch]                          = 1'b1;
                mwa_d[ch*ADDR_BITS +: ADDR_BITS]   = consumer_write_address[c*ADDR_BITS +: ADDR_BITS];
                mwd_d[ch*DATA_BITS +: DATA_BITS]   = consumer_write_data[c*DATA_BITS +: DATA_BITS];
                state_d[ch]                        = WRITE_WAITING;
              end
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[ch]) begin
            mrv_d[ch]                         = 1'b0;
            crd_d[own*DATA_BITS +: DATA_BITS] = mem_read_data[ch*DATA_BITS +: DATA_BITS];
            crr_d[own]                        = 1'b1;
            state_d[ch]                       = READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[ch]) begin
            mwv_d[ch]   = 1'b0;
            cwr_d[own]  = 1'b1;
            state_d[ch] = WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[own]) begin
            crr_d[own]     = 1'b0;
            serving_d[own] = 1'b0;
            state_d[ch]    = IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[own]) begin
            cwr_d[own]     = 1'b0;
            serving_d[own] = 1'b0;
            state_d[ch]    = IDLE;
          end
        end
        default: state_d[ch] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= IDLE;
        owner_q[ch] <= '0;
      end
      serving_q            <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      consumer_read_data   <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= state_d[ch];
        owner_q[ch] <= owner_d[ch];
      end
      serving_q            <= serving_d;
      consumer_read_ready  <= crr_d;
      consumer_write_ready <= cwr_d;
      consumer_read_data   <= crd_d;
      mem_read_valid       <= mrv_d;
      mem_read_address     <= mra_d;
      mem_write_valid      <= mwv_d;
      mem_write_address    <= mwa_d;
      mem_write_data       <= mwd_d;
    end
  end

`ifdef CONTROLLER_ASSERT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      if (NUM_CHANNELS > NUM_CONSUMERS)
        $error("controller: NUM_CHANNELS (%0d) exceeds NUM_CONSUMERS (%0d)", NUM_CHANNELS, NUM_CONSUMERS);
      for (int a = 0; a < NUM_CHANNELS; a++) begin
        for (int b = a + 1; b < NUM_CHANNELS; b++) begin
          if (state_q[a] != IDLE && state_q[b] != IDLE && owner_q[a] == owner_q[b])
            $error("controller: consumer %0d served by channels %0d and %0d", owner_q[a], a, b);
        end
        if (state_q[a] == IDLE && (mem_read_ready[a] || mem_write_ready[a]))
          $error("controller: memory ready on idle channel %0d", a);
      end
    end
  end
`endif

endmodule

// File: tb/tb_controller.sv
// Testbench for controller: a 1-channel read/write instance and a 2-channel read-only instance,
// driven with randomized requests and checked against a request-level memory/arbitration model.
module tb_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: one channel, writes enabled
  logic [3:0]  aRv, aRr, aWv, aWr;
  logic [31:0] aRa, aWa;
  logic [63:0] aRd, aWd;
  logic [0:0]  aMrv, aMrr, aMwv, aMwr;
  logic [7:0]  aMra, aMwa;
  logic [15:0] aMrd, aMwd;

  // Instance B: two channels, read-only
  logic [3:0]  bRv, bRr, bWv, bWr;
  logic [31:0] bRa, bWa;
  logic [63:0] bRd, bWd;
  logic [1:0]  bMrv, bMrr, bMwv, bMwr;
  logic [15:0] bMra, bMwa;
  logic [31:0] bMrd, bMwd;

  controller #(.NUM_CHANNELS(1), .WRITE_ENABLE(1)) dutA (
    .clk(clk), .reset(reset),
    .consumer_read_valid(aRv), .consumer_read_address(aRa),
    .consumer_read_ready(aRr), .consumer_read_data(aRd),
    .consumer_write_valid(aWv), .consumer_write_address(aWa),
    .consumer_write_data(aWd), .consumer_write_ready(aWr),
    .mem_read_valid(aMrv), .mem_read_address(aMra),
    .mem_read_ready(aMrr), .mem_read_data(aMrd),
    .mem_write_valid(aMwv), .mem_write_address(aMwa),
    .mem_write_data(aMwd), .mem_write_ready(aMwr)
  );

  controller #(.NUM_CHANNELS(2), .WRITE_ENABLE(0)) dutB (
    .clk(clk), .reset(reset),
    .consumer_read_valid(bRv), .consumer_read_address(bRa),
    .consumer_read_ready(bRr), .consumer_read_data(bRd),
    .consumer_write_valid(bWv), .consumer_write_address(bWa),
    .consumer_write_data(bWd), .consumer_write_ready(bWr),
    .mem_read_valid(bMrv), .mem_read_address(bMra),
    .mem_read_ready(bMrr), .mem_read_data(bMrd),
    .mem_write_valid(bMwv), .mem_write_address(bMwa),
    .mem_write_data(bMwd), .mem_write_ready(bMwr)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] modelMem [256];
  logic [7:0]  expRA [4];
  logic [7:0]  expWA [4];
  logic [15:0] expWD [4];
  logic [7:0]  bRA   [4];

  // Every comparison in the bench funnels through here
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Serve one request on instance A; consumer c is the one the arbitration rules say must win
  task automatic applyStimulus(input int c, input bit isW, input int lat);
    int waited;
    logic [15:0] rdata;
    waited = 0;
    rdata  = '0;
    while (waited < 20 && !(aMrv[0] || aMwv[0])) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("a_claim_latency", waited, 1);
    if (!(aMrv[0] || aMwv[0])) return;
    if (isW) begin
      checkOutput("a_mem_wvalid", aMwv[0], 1);
      checkOutput("a_mem_rvalid_off", aMrv[0], 0);
      checkOutput("a_mem_waddr", aMwa, expWA[c]);
      checkOutput("a_mem_wdata", aMwd, expWD[c]);
      aWa[c*8 +: 8]   = 8'($urandom);
      aWd[c*16 +: 16] = 16'($urandom);
    end else begin
      checkOutput("a_mem_rvalid", aMrv[0], 1);
      checkOutput("a_mem_wvalid_off", aMwv[0], 0);
      checkOutput("a_mem_raddr", aMra, expRA[c]);
      aRa[c*8 +: 8] = 8'($urandom);
    end
    if (lat < 0) lat = $urandom_range(0, 3);
    repeat (lat) @(negedge clk);
    if (isW) checkOutput("a_waddr_held", aMwa, expWA[c]);
    else     checkOutput("a_raddr_held", aMra, expRA[c]);
    if (isW) begin
      aMwr = 1'b1;
      @(negedge clk);
      aMwr = 1'b0;
      modelMem[expWA[c]] = expWD[c];
      checkOutput("a_wr_ready", aWr, 64'(1 << c));
      checkOutput("a_mem_wvalid_clr", aMwv[0], 0);
    end else begin
      rdata = modelMem[expRA[c]];
      aMrr  = 1'b1;
      aMrd  = rdata;
      @(negedge clk);
      aMrr  = 1'b0;
      aMrd  = 16'($urandom);
      checkOutput("a_rd_ready", aRr, 64'(1 << c));
      checkOutput("a_rd_data", aRd[c*16 +: 16], rdata);
      checkOutput("a_mem_rvalid_clr", aMrv[0], 0);
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    checkOutput("a_ready_hold", isW ? aWr : aRr, 64'(1 << c));
    if (isW) aWv[c] = 1'b0;
    else     aRv[c] = 1'b0;
    @(negedge clk);
    checkOutput("a_ready_clr", isW ? aWr : aRr, 0);
    if (!isW) checkOutput("a_rd_data_hold", aRd[c*16 +: 16], rdata);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c0, c1, waited, lat, c;
    logic [3:0] pr, pw, mask, k;
    logic [15:0] d0, d1;
    logic [63:0] expReady;

    for (int i = 0; i < 256; i++) modelMem[i] = 16'($urandom);
    reset = 1'b0;
    aRv = '0; aRa = '0; aWv = '0; aWa = '0; aWd = '0;
    aMrr = '0; aMrd = '0; aMwr = '0;
    bRv = '0; bRa = '0; bWv = '0; bWa = '0; bWd = '0;
    bMrr = '0; bMrd = '0; bMwr = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_a_mrv", aMrv, 0);
    checkOutput("rst_a_ready", {aRr, aWr}, 0);
    checkOutput("rst_a_rdata", aRd, 0);
    checkOutput("rst_b_mrv", bMrv, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single read: consumer 2, address 0x10, memory answers after 3 cycles
    expRA[2] = 8'h10;
    modelMem[8'h10] = 16'hBEEF;
    aRa[23:16] = 8'h10;
    aRv[2] = 1'b1;
    applyStimulus(2, 1'b0, 3);

    // Write: consumer 0 writes 0x1234 to 0x05
    expWA[0] = 8'h05;
    expWD[0] = 16'h1234;
    aWa[7:0]  = 8'h05;
    aWd[15:0] = 16'h1234;
    aWv[0] = 1'b1;
    applyStimulus(0, 1'b1, 1);

    // Randomized rounds; round 0 is the 0-and-3 read contention case
    for (int r = 0; r < 12; r++) begin
      pr = '0;
      pw = '0;
      for (int i = 0; i < 4; i++) begin
        k = 4'($urandom_range(0, 3));
        pr[i] = k[0];
        pw[i] = k[1];
        expRA[i] = 8'($urandom);
        expWA[i] = 8'($urandom);
        expWD[i] = 16'($urandom);
      end
      if (r == 0) begin
        pr = 4'b1001;
        pw = 4'b0000;
      end
      for (int i = 0; i < 4; i++) begin
        aRa[i*8 +: 8]   = expRA[i];
        aWa[i*8 +: 8]   = expWA[i];
        aWd[i*16 +: 16] = expWD[i];
      end
      aRv = pr;
      aWv = pw;
      for (int s = 0; s < 8 && (pr | pw) != 0; s++) begin
        c = 0;
        for (int i = 3; i >= 0; i--) if (pr[i] | pw[i]) c = i;
        applyStimulus(c, !pr[c], -1);
        if (pr[c]) pr[c] = 1'b0;
        else       pw[c] = 1'b0;
      end
    end

    // Reset during READ_WAITING, then a normal read
    expRA[1] = 8'h33;
    aRa[15:8] = 8'h33;
    aRv[1] = 1'b1;
    @(negedge clk);
    checkOutput("pre_rst_mrv", aMrv, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_rst_mrv", aMrv, 0);
    checkOutput("async_rst_mra", aMra, 0);
    checkOutput("async_rst_rdata", aRd, 0);
    checkOutput("async_rst_ready", aRr, 0);
    @(negedge clk);
    aRv = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_quiet", {aMrv, aMwv, aRr, aWr}, 0);
    expRA[1] = 8'($urandom);
    aRa[15:8] = expRA[1];
    aRv[1] = 1'b1;
    applyStimulus(1, 1'b0, -1);

    // Instance B: write requests must be ignored throughout
    for (int i = 0; i < 4; i++) begin
      bWa[i*8 +: 8]   = 8'($urandom);
      bWd[i*16 +: 16] = 16'($urandom);
    end
    bWv = 4'b0101;
    repeat (4) @(negedge clk);
    checkOutput("b_wr_ignored_mwv", bMwv, 0);
    checkOutput("b_wr_ignored_ready", bWr, 0);
    checkOutput("b_wr_ignored_mrv", bMrv, 0);

    // Two-channel rounds; round 0 is consumers 1 and 2 on the same edge
    for (int r = 0; r < 10; r++) begin
      mask = (r == 0) ? 4'b0110 : 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        bRA[i] = 8'($urandom);
        bRa[i*8 +: 8] = bRA[i];
      end
      bRv = mask;
      for (int s = 0; s < 4 && mask != 0; s++) begin
        c0 = -1;
        c1 = -1;
        for (int i = 0; i < 4; i++) begin
          if (mask[i]) begin
            if (c0 < 0)      c0 = i;
            else if (c1 < 0) c1 = i;
          end
        end
        waited = 0;
        while (waited < 20 && !bMrv[0]) begin
          @(negedge clk);
          waited++;
        end
        checkOutput("b_claim_latency", waited, 1);
        checkOutput("b_ch1_valid", bMrv[1], (c1 >= 0) ? 1 : 0);
        checkOutput("b_ch0_addr", bMra[7:0], bRA[c0]);
        if (c1 >= 0) checkOutput("b_ch1_addr", bMra[15:8], bRA[c1]);
        checkOutput("b_mem_wvalid", bMwv, 0);
        lat = $urandom_range(0, 3);
        repeat (lat) @(negedge clk);
        d0 = 16'($urandom);
        d1 = 16'($urandom);
        bMrr = {c1 >= 0, 1'b1};
        bMrd = {d1, d0};
        @(negedge clk);
        bMrr = '0;
        expReady = 64'(1 << c0);
        if (c1 >= 0) expReady = expReady | 64'(1 << c1);
        checkOutput("b_rd_ready", bRr, expReady);
        checkOutput("b_rd_data0", bRd[c0*16 +: 16], d0);
        if (c1 >= 0) checkOutput("b_rd_data1", bRd[c1*16 +: 16], d1);
        bRv[c0] = 1'b0;
        mask[c0] = 1'b0;
        if (c1 >= 0) begin
          bRv[c1] = 1'b0;
          mask[c1] = 1'b0;
        end
        @(negedge clk);
        checkOutput("b_ready_clr", bRr, 0);
        checkOutput("b_wr_ready_off", bWr, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
